// File: rtl/rob_rollback_unit.sv
// ROB branch-recovery rollback: walks back from the tail, squashing one entry per cycle, then restores the tail.
// Optional ROLLBACK_STATS_EN builds a saturating 16-bit counter of completed rollbacks.
module rob_rollback_unit #(
  parameter int unsigned PTR_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 recover_i,
  input  logic [PTR_WIDTH-1:0] recover_ptr_i,
  input  logic [PTR_WIDTH-1:0] rob_tail_i,
  output logic                 busy_o,
  output logic                 squash_valid_o,
  output logic [PTR_WIDTH-1:0] squash_idx_o,
  output logic                 tail_restore_o,
  output logic [PTR_WIDTH-1:0] tail_restore_ptr_o,
  output logic                 done_o,
  output logic [PTR_WIDTH-1:0] squash_count_o,
  output logic                 recover_dropped_o,
  output logic [15:0]          rollback_events_o
);

  typedef enum logic [1:0] {IDLE, WALK, FINISH} state_e;

  localparam logic [PTR_WIDTH-1:0] ONE = PTR_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 recover_prev_q;
  logic [PTR_WIDTH-1:0] rp_q, rp_d;
  logic [PTR_WIDTH-1:0] wp_q, wp_d;
  logic                 busy_q, busy_d;
  logic                 squash_valid_q, squash_valid_d;
  logic [PTR_WIDTH-1:0] squash_idx_q, squash_idx_d;
  logic                 tail_restore_q, tail_restore_d;
  logic [PTR_WIDTH-1:0] tail_restore_ptr_q, tail_restore_ptr_d;
  logic                 done_q, done_d;
  logic [PTR_WIDTH-1:0] squash_count_q, squash_count_d;
  logic                 dropped_q, dropped_d;

  logic                 recover_rise;
  logic [PTR_WIDTH-1:0] n_calc;
  logic [PTR_WIDTH-1:0] tail_dec;
  logic [PTR_WIDTH-1:0] rp_inc;
  logic [PTR_WIDTH-1:0] wp_dec;

  assign recover_rise = recover_i & ~recover_prev_q;
  assign tail_dec     = rob_tail_i - ONE;
  assign n_calc       = rob_tail_i - recover_ptr_i - ONE;
  assign rp_inc       = rp_q + ONE;
  assign wp_dec       = wp_q - ONE;

  // Every output is computed one cycle ahead from the next state so it can be registered.
  always_comb begin
    state_d            = state_q;
    rp_d               = rp_q;
    wp_d               = wp_q;
    squash_valid_d     = 1'b0;
    squash_idx_d       = squash_idx_q;
    tail_restore_d     = 1'b0;
    tail_restore_ptr_d = tail_restore_ptr_q;
    done_d             = 1'b0;
    squash_count_d     = squash_count_q;
    dropped_d          = recover_rise && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (recover_rise) begin
          rp_d           = recover_ptr_i;
          squash_count_d = n_calc;
          if (n_calc != '0) begin
            state_d        = WALK;
            wp_d           = tail_dec;
            squash_valid_d = 1'b1;
            squash_idx_d   = tail_dec;
          end else begin
            state_d            = FINISH;
            tail_restore_d     = 1'b1;
            done_d             = 1'b1;
            tail_restore_ptr_d = recover_ptr_i + ONE;
          end
        end
      end
      WALK: begin
        // wp_q is the index being shown this cycle; the entry just above the branch ends the walk.
        if (wp_q == rp_inc) begin
          state_d            = FINISH;
          tail_restore_d     = 1'b1;
          done_d             = 1'b1;
          tail_restore_ptr_d = rp_inc;
        end else begin
          wp_d           = wp_dec;
          squash_valid_d = 1'b1;
          squash_idx_d   = wp_dec;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q            <= IDLE;
      recover_prev_q     <= 1'b0;
      rp_q               <= '0;
      wp_q               <= '0;
      busy_q             <= 1'b0;
      squash_valid_q     <= 1'b0;
      squash_idx_q       <= '0;
      tail_restore_q     <= 1'b0;
      tail_restore_ptr_q <= '0;
      done_q             <= 1'b0;
      squash_count_q     <= '0;
      dropped_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      recover_prev_q     <= recover_i;
      rp_q               <= rp_d;
      wp_q               <= wp_d;
      busy_q             <= busy_d;
      squash_valid_q     <= squash_valid_d;
      squash_idx_q       <= squash_idx_d;
      tail_restore_q     <= tail_restore_d;
      tail_restore_ptr_q <= tail_restore_ptr_d;
      done_q             <= done_d;
      squash_count_q     <= squash_count_d;
      dropped_q          <= dropped_d;
    end
  end

`ifdef ROLLBACK_STATS_EN
  logic [15:0] events_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      events_q <= '0;
    end else if (done_d && (events_q != '1)) begin
      events_q <= events_q + 16'd1;
    end
  end

  assign rollback_events_o = events_q;
`else
  assign rollback_events_o = '0;
`endif

  assign busy_o             = busy_q;
  assign squash_valid_o     = squash_valid_q;
  assign squash_idx_o       = squash_idx_q;
  assign tail_restore_o     = tail_restore_q;
  assign tail_restore_ptr_o = tail_restore_ptr_q;
  assign done_o             = done_q;
  assign squash_count_o     = squash_count_q;
  assign recover_dropped_o  = dropped_q;

endmodule

// File: tb/tb_rob_rollback_unit.sv
// Scoreboard bench for rob_rollback_unit (PTR_WIDTH=4): expected squash indices and restore pointers
// are queued when a recovery is driven and popped as the DUT emits them.
module tb_rob_rollback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        recover;
  logic [3:0]  recover_ptr;
  logic [3:0]  rob_tail;
  logic        busy;
  logic        squash_valid;
  logic [3:0]  squash_idx;
  logic        tail_restore;
  logic [3:0]  tail_restore_ptr;
  logic        done;
  logic [3:0]  squash_count;
  logic        recover_dropped;
  logic [15:0] rollback_events;

  rob_rollback_unit #(.PTR_WIDTH(4)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .recover_i          (recover),
    .recover_ptr_i      (recover_ptr),
    .rob_tail_i         (rob_tail),
    .busy_o             (busy),
    .squash_valid_o     (squash_valid),
    .squash_idx_o       (squash_idx),
    .tail_restore_o     (tail_restore),
    .tail_restore_ptr_o (tail_restore_ptr),
    .done_o             (done),
    .squash_count_o     (squash_count),
    .recover_dropped_o  (recover_dropped),
    .rollback_events_o  (rollback_events)
  );

  always #5 clk = ~clk;

`ifdef ROLLBACK_STATS_EN
  localparam logic [15:0] EXP_EVENTS = 16'd3;
`else
  localparam logic [15:0] EXP_EVENTS = 16'd0;
`endif

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  int drop_seen = 0;
  logic [3:0] exp_idx_q[$];
  logic [3:0] exp_ptr_q[$];
  logic [3:0] exp_e;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (squash_valid === 1'b1) begin
        checks++;
        if (exp_idx_q.size() == 0) begin
          $display("FAIL unexpected_squash: got idx=%0d, required no squash", squash_idx);
        end else begin
          exp_e = exp_idx_q.pop_front();
          if (squash_idx !== exp_e) $display("FAIL squash_idx: got %0d, required %0d", squash_idx, exp_e);
          else passes++;
        end
      end
      if (done === 1'b1) begin
        done_seen++;
        checks++;
        if (exp_ptr_q.size() == 0) begin
          $display("FAIL unexpected_done: got done with ptr=%0d, required no done", tail_restore_ptr);
        end else begin
          exp_e = exp_ptr_q.pop_front();
          if (tail_restore_ptr !== exp_e || tail_restore !== 1'b1 || squash_valid !== 1'b0)
            $display("FAIL tail_restore: got ptr=%0d tr=%b sv=%b, required ptr=%0d tr=1 sv=0",
                     tail_restore_ptr, tail_restore, squash_valid, exp_e);
          else passes++;
        end
      end
      if (recover_dropped === 1'b1) drop_seen++;
    end
  end

  task automatic expect_walk(input logic [3:0] tail, input logic [3:0] rp);
    logic [3:0] n;
    n = tail - rp - 4'd1;
    for (int k = 0; k < int'(n); k++) exp_idx_q.push_back(tail - 4'd1 - 4'(k));
    exp_ptr_q.push_back(rp + 4'd1);
  endtask

  // Called at a falling edge; drives a one-cycle request and returns how many cycles busy stayed high.
  task automatic run_rollback(input logic [3:0] tail, input logic [3:0] rp, output int busy_cyc);
    expect_walk(tail, rp);
    rob_tail = tail;
    recover_ptr = rp;
    recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    rob_tail = ~tail;
    recover_ptr = ~rp;
    busy_cyc = 0;
    while (busy === 1'b1 && busy_cyc <= 40) begin
      busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; recover = 1'b0; recover_ptr = 4'd0; rob_tail = 4'd0;
    #12;
    checks++;
    if ({busy, squash_valid, tail_restore, done, recover_dropped, squash_idx, tail_restore_ptr,
         squash_count, rollback_events} !== 33'd0)
      $display("FAIL reset_state: got busy=%b sv=%b tr=%b done=%b drop=%b idx=%0d ptr=%0d cnt=%0d ev=%0d, required all 0",
               busy, squash_valid, tail_restore, done, recover_dropped, squash_idx, tail_restore_ptr,
               squash_count, rollback_events);
    else passes++;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_walk();
    int bc; int d0;
    d0 = done_seen;
    run_rollback(4'd9, 4'd5, bc);
    checks++; if (bc !== 4) $display("FAIL basic_busy_cycles: got %0d, required 4", bc); else passes++;
    checks++; if (squash_count !== 4'd3) $display("FAIL basic_squash_count: got %0d, required 3", squash_count); else passes++;
    checks++; if (done_seen - d0 !== 1 || exp_idx_q.size() != 0)
      $display("FAIL basic_complete: got done=%0d left=%0d, required done=1 left=0", done_seen - d0, exp_idx_q.size());
    else passes++;
  endtask

  task automatic test_wrap();
    int bc;
    run_rollback(4'd2, 4'd13, bc);
    checks++; if (bc !== 5) $display("FAIL wrap_busy_cycles: got %0d, required 5", bc); else passes++;
    checks++; if (squash_count !== 4'd4) $display("FAIL wrap_squash_count: got %0d, required 4", squash_count); else passes++;
    checks++; if (exp_idx_q.size() != 0 || exp_ptr_q.size() != 0)
      $display("FAIL wrap_complete: got left=%0d/%0d, required 0/0", exp_idx_q.size(), exp_ptr_q.size());
    else passes++;
  endtask

  task automatic test_zero_squash();
    int bc;
    run_rollback(4'd6, 4'd5, bc);
    checks++; if (bc !== 1) $display("FAIL zero_busy_cycles: got %0d, required 1", bc); else passes++;
    checks++; if (squash_count !== 4'd0) $display("FAIL zero_squash_count: got %0d, required 0", squash_count); else passes++;
    checks++; if (exp_ptr_q.size() != 0) $display("FAIL zero_done_missing: got left=%0d, required 0", exp_ptr_q.size()); else passes++;
  endtask

  task automatic test_full_rob();
    int bc;
    run_rollback(4'd3, 4'd3, bc);
    checks++; if (bc !== 16) $display("FAIL full_busy_cycles: got %0d, required 16", bc); else passes++;
    checks++; if (squash_count !== 4'd15) $display("FAIL full_squash_count: got %0d, required 15", squash_count); else passes++;
    checks++; if (exp_idx_q.size() != 0 || exp_ptr_q.size() != 0)
      $display("FAIL full_complete: got left=%0d/%0d, required 0/0", exp_idx_q.size(), exp_ptr_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int bc1; int bc2; int d0;
    d0 = done_seen;
    run_rollback(4'd11, 4'd8, bc1);
    run_rollback(4'd1, 4'd14, bc2);
    checks++; if (bc1 !== 3 || bc2 !== 3)
      $display("FAIL b2b_busy_cycles: got %0d,%0d, required 3,3", bc1, bc2);
    else passes++;
    checks++; if (done_seen - d0 !== 2 || exp_idx_q.size() != 0)
      $display("FAIL b2b_complete: got done=%0d left=%0d, required done=2 left=0", done_seen - d0, exp_idx_q.size());
    else passes++;
  endtask

  task automatic test_stuck_high();
    int d0; int r0;
    d0 = done_seen; r0 = drop_seen;
    expect_walk(4'd9, 4'd5);
    rob_tail = 4'd9; recover_ptr = 4'd5; recover = 1'b1;
    repeat (20) @(negedge clk);
    recover = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_seen - d0 !== 1) $display("FAIL stuck_rollbacks: got %0d, required 1", done_seen - d0); else passes++;
    checks++; if (drop_seen - r0 !== 0) $display("FAIL stuck_dropped: got %0d, required 0", drop_seen - r0); else passes++;
  endtask

  task automatic test_overlap();
    int bc; int d0; int r0;
    d0 = done_seen; r0 = drop_seen;
    expect_walk(4'd12, 4'd2);
    rob_tail = 4'd12; recover_ptr = 4'd2; recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc <= 40) begin
      bc++;
      if (bc == 3) begin recover = 1'b1; recover_ptr = 4'd7; rob_tail = 4'd0; end
      if (bc == 4) recover = 1'b0;
      @(negedge clk);
    end
    checks++; if (drop_seen - r0 !== 1) $display("FAIL overlap_dropped: got %0d, required 1", drop_seen - r0); else passes++;
    checks++; if (bc !== 10) $display("FAIL overlap_busy_cycles: got %0d, required 10", bc); else passes++;
    checks++; if (squash_count !== 4'd9 || done_seen - d0 !== 1)
      $display("FAIL overlap_walk: got cnt=%0d done=%0d, required cnt=9 done=1", squash_count, done_seen - d0);
    else passes++;
  endtask

  task automatic test_reset_mid_walk();
    int d0; int bc;
    expect_walk(4'd9, 4'd1);
    rob_tail = 4'd9; recover_ptr = 4'd1; recover = 1'b1;
    @(negedge clk);
    recover = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, squash_valid, tail_restore, done, recover_dropped, squash_idx, tail_restore_ptr,
         squash_count, rollback_events} !== 33'd0)
      $display("FAIL midwalk_reset: got busy=%b sv=%b idx=%0d cnt=%0d ev=%0d, required all 0",
               busy, squash_valid, squash_idx, squash_count, rollback_events);
    else passes++;
    exp_idx_q.delete();
    exp_ptr_q.delete();
    d0 = done_seen;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (done_seen !== d0 || busy !== 1'b0)
      $display("FAIL midwalk_no_done: got done=%0d busy=%b, required done=0 busy=0", done_seen - d0, busy);
    else passes++;
    run_rollback(4'd9, 4'd5, bc);
    run_rollback(4'd6, 4'd5, bc);
    run_rollback(4'd2, 4'd13, bc);
    checks++; if (rollback_events !== EXP_EVENTS)
      $display("FAIL rollback_events: got %0d, required %0d", rollback_events, EXP_EVENTS);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_walk();
    test_wrap();
    test_zero_squash();
    test_full_rob();
    test_back_to_back();
    test_stuck_high();
    test_overlap();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
